// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: elastic two-slot (main + skid) stage with flush,
// carrying the EX bundle plus a branch decision resolved at capture time.
module ex_mem_pipe_reg #(
    parameter int DATA_W  = 64,
    parameter int FUNCT_W = 4,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         ctrl_in,
    input  logic [DATA_W-1:0]  pc_plus_imm_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [DATA_W-1:0]  write_data_in,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic [RD_W-1:0]    rd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         ctrl_store,
    output logic               branch_taken_store,
    output logic [DATA_W-1:0]  pc_plus_imm_store,
    output logic [DATA_W-1:0]  alu_result_store,
    output logic [DATA_W-1:0]  write_data_store,
    output logic [FUNCT_W-1:0] funct_store,
    output logic [RD_W-1:0]    rd_store
);

    typedef struct packed {
        logic [6:0]         ctrl;
        logic               taken;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  wd;
        logic [FUNCT_W-1:0] funct;
        logic [RD_W-1:0]    rd;
    } slot_t;

    slot_t mSlot_q, mSlot_d, sSlot_q, sSlot_d, inSlot;
    logic  mValid_q, mValid_d, sValid_q, sValid_d;
    logic  inFire, outFire;

    // ctrl bit map: 4 = Branch, 3 = Zero, 0 = Is_Greater
    function automatic logic branchTaken(input logic [6:0] ctrl, input logic [2:0] f3);
        logic cond;
        case (f3)
            3'b000:  cond = ctrl[3];
            3'b001:  cond = ~ctrl[3];
            3'b100:  cond = ~ctrl[0] & ~ctrl[3];
            3'b101:  cond = ctrl[0] | ctrl[3];
            default: cond = 1'b0;
        endcase
        return ctrl[4] & cond;
    endfunction

    always_comb begin
        inFire  = in_valid & ~sValid_q;
        outFire = mValid_q & out_ready;

        inSlot.ctrl  = ctrl_in;
        inSlot.taken = branchTaken(ctrl_in, funct_in[2:0]);
        inSlot.pc    = pc_plus_imm_in;
        inSlot.alu   = alu_result_in;
        inSlot.wd    = write_data_in;
        inSlot.funct = funct_in;
        inSlot.rd    = rd_in;

        mSlot_d  = mSlot_q;
        sSlot_d  = sSlot_q;
        mValid_d = mValid_q;
        sValid_d = sValid_q;

        // Empty slots keep their data but zero ctrl/taken so a bubble is a NOP.
        if (flush) begin
            mValid_d      = 1'b0;
            sValid_d      = 1'b0;
            mSlot_d.ctrl  = '0;
            mSlot_d.taken = 1'b0;
            sSlot_d.ctrl  = '0;
            sSlot_d.taken = 1'b0;
        end else if (!mValid_q || outFire) begin
            if (sValid_q) begin
                mSlot_d  = sSlot_q;
                mValid_d = 1'b1;
            end else if (inFire) begin
                mSlot_d  = inSlot;
                mValid_d = 1'b1;
            end else begin
                mValid_d      = 1'b0;
                mSlot_d.ctrl  = '0;
                mSlot_d.taken = 1'b0;
            end
            sValid_d      = 1'b0;
            sSlot_d.ctrl  = '0;
            sSlot_d.taken = 1'b0;
        end else if (inFire) begin
            sSlot_d  = inSlot;
            sValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mSlot_q  <= '0;
            sSlot_q  <= '0;
            mValid_q <= 1'b0;
            sValid_q <= 1'b0;
        end else begin
            mSlot_q  <= mSlot_d;
            sSlot_q  <= sSlot_d;
            mValid_q <= mValid_d;
            sValid_q <= sValid_d;
        end
    end

    assign in_ready           = ~sValid_q;
    assign out_valid          = mValid_q;
    assign ctrl_store         = mSlot_q.ctrl;
    assign branch_taken_store = mSlot_q.taken;
    assign pc_plus_imm_store  = mSlot_q.pc;
    assign alu_result_store   = mSlot_q.alu;
    assign write_data_store   = mSlot_q.wd;
    assign funct_store        = mSlot_q.funct;
    assign rd_store           = mSlot_q.rd;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register. Replaces the fixed 64-bit, free-running negedge latch with an elastic, flushable stage.
- Valid/ready handshake on both sides.
- 2-slot skid buffer (main + skid) gives full throughput under back-pressure.
- Branch resolution (taken/not-taken) is computed on capture and registered, so the MEM stage receives a ready-made PCSrc bit.
- Sits between the EX stage (ALU, branch comparator) and the MEM stage / hazard unit.

Parameters:
- DATA_W, 64, width of pc_plus_imm, alu_result, write_data.
- FUNCT_W, 4, width of funct field; must be >= 3.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (taken branch / exception).
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  stage can accept a bundle this cycle.
- ctrl_in  in  7  {RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, Is_Greater}, bit 6 = RegWrite, bit 0 = Is_Greater.
- pc_plus_imm_in  in  DATA_W  branch target.
- alu_result_in  in  DATA_W  ALU result / address.
- write_data_in  in  DATA_W  store data.
- funct_in  in  FUNCT_W  funct bits; [2:0] = funct3.
- rd_in  in  RD_W  destination register.
- out_valid  out  1  MEM-side bundle valid.
- out_ready  in  1  MEM stage accepts the bundle.
- ctrl_store  out  7  registered ctrl_in, same bit map.
- branch_taken_store  out  1  registered branch decision.
- pc_plus_imm_store, alu_result_store, write_data_store  out  DATA_W each  registered data.
- funct_store  out  FUNCT_W  registered funct.
- rd_store  out  RD_W  registered rd.

Behaviour:
- Storage: main slot M drives all *_store outputs. Skid slot S holds one extra bundle. Each slot has its own valid bit.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = M.valid.
  - in_ready = ~S.valid (registered, no combinational path from out_ready).
- Invariant: S.valid implies M.valid.
- Update rule when no flush and no reset:
  - If ~M.valid or out_fire: M <= S if S.valid, else input if in_fire, else empty. S <= empty.
  - Otherwise, if in_fire: S <= input, and M holds.
- Latency: one cycle from in_fire to out_valid when the stage is empty. Sustains one bundle per cycle while out_ready = 1.
- Branch decision: computed from the input bundle at capture and stored with it in the slot (M or S). taken = Branch & cond(funct[2:0]), where:
  - 000 (beq) -> Zero
  - 001 (bne) -> ~Zero
  - 100 (blt) -> ~Is_Greater & ~Zero
  - 101 (bge) -> Is_Greater | Zero
  - all other codes -> 0
- Empty-slot contents: ctrl and taken bits of any empty slot are 0, so a bubble is a NOP. Data fields of an empty slot hold their last value.
- flush:
  - Next cycle, M.valid = S.valid = 0 and all ctrl/taken bits are 0.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed.
  - flush takes priority over any capture.
- reset:
  - Next cycle, both valids, all ctrl, branch_taken_store and all data outputs are 0.
  - in_ready = 1 after reset.
  - reset overrides flush and any handshake.
  - reset asserted mid-stream drops all held bundles.
- Back-pressure: with out_ready = 0, M holds stable. At most one further bundle is accepted, into S, and in_ready then drops to 0. When out_ready rises, M <= S in the same edge and in_ready returns to 1 on the next cycle.
- Simultaneous in_fire and out_fire with S empty: M is replaced by the input and no bubble is inserted.
- No X propagation: all storage is reset.

Test Plan:
1. Reset, then in_valid = 1 with ctrl_in = 7'b1000000, alu_result_in = 64'h10, rd_in = 5, out_ready = 1 -> next cycle out_valid = 1, ctrl_store = 7'b1000000, alu_result_store = 64'h10, rd_store = 5, branch_taken_store = 0.
2. Stream 4 bundles with alu_result = 1, 2, 3, 4 back-to-back, out_ready = 1 -> outputs 1, 2, 3, 4 on consecutive cycles; in_ready stays 1.
3. Hold out_ready = 0 and send A = 1 then B = 2 -> M = A, S = B, in_ready = 0 on the cycle after B. Raise out_ready -> A consumed, then B on the next cycle, no loss or duplication; in_ready returns to 1.
4. Branch = 1, Zero = 0, funct = 4'b0001 -> branch_taken_store = 1. Same bundle with funct = 4'b0000 -> 0. Is_Greater = 1 with funct = 4'b0101 -> 1. funct = 4'b0010 -> 0.
5. With M and S both full, assert flush together with in_valid = 1 -> next cycle out_valid = 0, ctrl_store = 0, branch_taken_store = 0, in_ready = 1, and the flushed input never appears at the output.
6. Assert reset mid-stream together with flush and in_valid -> next cycle all outputs = 0, out_valid = 0, in_ready = 1.
